// File: rtl/cnn_pkg.sv
// Shared types and widths for the CNN result-path blocks.
package cnn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } fsm_state_t;

    localparam int PIX_W        = 8;
    localparam int WORD_W       = 32;
    localparam int PIX_PER_WORD = 4;

endpackage

// File: rtl/fmap_pack4.sv
// Four-lane little-endian pixel pack register with optional ReLU (FMAP_WR_RELU_EN).
// word_o is combinational: the held lanes with the incoming pixel merged into lane_i.
module fmap_pack4
    import cnn_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic [1:0]        lane_i,
    input  logic [PIX_W-1:0]  pix_i,
    output logic [WORD_W-1:0] word_o
);

    logic [WORD_W-1:0] pack_q;
    logic [WORD_W-1:0] pack_d;
    logic [PIX_W-1:0]  pix_eff;

`ifdef FMAP_WR_RELU_EN
    assign pix_eff = pix_i[PIX_W-1] ? '0 : pix_i;
`else
    assign pix_eff = pix_i;
`endif

    always_comb begin
        word_o = pack_q;
        word_o[lane_i*PIX_W +: PIX_W] = pix_eff;
    end

    // Clearing wins over loading so a completed group leaves zeros for the next one.
    always_comb begin
        pack_d = pack_q;
        if (clr_i) begin
            pack_d = '0;
        end else if (load_i) begin
            pack_d = word_o;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pack_q <= '0;
        end else begin
            pack_q <= pack_d;
        end
    end

endmodule

// File: rtl/fmap_writer.sv
// Packs a signed 8-bit pixel stream into 32-bit words and writes them to memory; word
// write follows the 4th pixel by 1 cycle, a stalled write holds and drops in_ready. Macro: FMAP_WR_RELU_EN.
module fmap_writer
    import cnn_pkg::*;
#(
    parameter int IMG_W     = 26,
    parameter int IMG_H     = 26,
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [PIX_W-1:0]  in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done
);

    localparam int NPIX  = IMG_W * IMG_H;
    localparam int CNT_W = 16;

    fsm_state_t        state_q;
    logic [CNT_W-1:0]  pix_cnt_q;
    logic [1:0]        lane_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic              busy_q;
    logic              done_q;

    logic              stall;
    logic              accept;
    logic              last_pix;
    logic              word_full;
    logic              start_acc;
    logic [WORD_W-1:0] pack_word;

    assign stall     = we_q & ~mem_ready;
    assign in_ready  = (state_q == ST_RUN) & ~stall;
    assign accept    = in_valid & in_ready;
    assign last_pix  = (pix_cnt_q == CNT_W'(NPIX - 1));
    // The final pixel closes its group early; the unused upper lanes are still zero.
    assign word_full = (lane_q == 2'd3) | last_pix;
    assign start_acc = start & (state_q == ST_IDLE);

    fmap_pack4 u_pack (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (start_acc | (accept & word_full)),
        .load_i (accept),
        .lane_i (lane_q),
        .pix_i  (in_data),
        .word_o (pack_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pix_cnt_q <= '0;
            lane_q    <= '0;
            we_q      <= 1'b0;
            addr_q    <= ADDR_W'(BASE_ADDR);
            wdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (we_q && mem_ready) begin
                we_q   <= 1'b0;
                addr_q <= addr_q + ADDR_W'(1);
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_acc) begin
                        state_q   <= ST_RUN;
                        busy_q    <= 1'b1;
                        pix_cnt_q <= '0;
                        lane_q    <= '0;
                        addr_q    <= ADDR_W'(BASE_ADDR);
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        pix_cnt_q <= pix_cnt_q + CNT_W'(1);
                        lane_q    <= lane_q + 2'd1;
                        if (word_full) begin
                            we_q    <= 1'b1;
                            wdata_q <= pack_word;
                        end
                        if (last_pix) begin
                            state_q <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (!we_q || mem_ready) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
